engine_arb: RTL and testbench
=============================

ENGINE_ARB -- requirements
Module: engine_arb

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  request from requester i; held high until gnt[i].
REQ-005 Port: a_in  input  4*WIDTH  operand of requester i at bits [i*WIDTH +: WIDTH]; stable while req[i] is high.
REQ-006 Port: gnt  output  4  one-hot, one-cycle acceptance pulse; operand captured on that edge.
REQ-007 Port: rsp_valid  output  1  result available.
REQ-008 Port: rsp_id  output  2  index of the requester owning the result.
REQ-009 Port: rsp_z  output  WIDTH  result, a*3 mod 2^WIDTH.
REQ-010 Port: rsp_ready  input  1  consumer accepts the result when high with rsp_valid.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: ovf  output  1  a*3 exceeded 2^WIDTH-1; present only under ENGINE_ARB_OVF_EN.

Function
REQ-013 One shared times-3 engine instance; only the latched operand drives it.
REQ-014 FSM states: IDLE, CALC, HOLD.
REQ-015 IDLE: if any req bit is high, grant the first requester at or after rr_ptr, wrapping 3->0; pulse gnt, latch operand and id, go to CALC.
REQ-016 IDLE with req==0: stay in IDLE; gnt=0.
REQ-017 CALC: register the engine output into rsp_z, set rsp_valid, go to HOLD; lasts exactly one cycle.
REQ-018 Latency: gnt high in cycle T gives rsp_valid high in cycle T+2.
REQ-019 HOLD: rsp_valid, rsp_id, rsp_z and ovf stay stable until rsp_valid&rsp_ready.
REQ-020 On the accept edge: clear rsp_valid, set rr_ptr=rsp_id+1 mod 4, go to IDLE.
REQ-021 Minimum spacing between grants: 3 cycles, when rsp_ready is held high.
REQ-022 gnt is 0 in CALC and HOLD; requests arriving then wait and are not lost.
REQ-023 rsp_z is the low WIDTH bits of 3*a; the carry is discarded.
REQ-024 Fairness: with all four requests held continuously, the grant order repeats 0,1,2,3.
REQ-025 A req deasserted before its gnt is ignored; this is illegal by protocol, not an error.

Reset
REQ-026 When reset is high at a rising edge, the next state is IDLE, rr_ptr=0, gnt=0, rsp_valid=0, rsp_id=0, rsp_z=0, ovf=0, busy=0.
REQ-027 Reset in CALC or HOLD discards the in-flight result; no rsp_valid follows for it.
REQ-028 Reset has priority over every other event in the same cycle, including an accept.

Configuration
REQ-029 Macro ENGINE_ARB_OVF_EN defined: the ovf port exists and is registered in CALC as the bit-WIDTH carry of 3*a.
REQ-030 Macro ENGINE_ARB_OVF_EN undefined: no ovf port and no ovf logic; all other behaviour is identical.

Verification
REQ-031 Scenario: after reset, req=4'b0001 and a0=5 -> gnt=0001 at T; at T+2 rsp_valid=1, rsp_id=0, rsp_z=15.
REQ-032 Scenario: a2=32'hFFFFFFFF, req=0100 -> rsp_z=32'hFFFFFFFD, rsp_id=2, ovf=1 (macro on); a=32'h55555555 gives ovf=0 and rsp_z=32'hFFFFFFFF.
REQ-033 Scenario: req=1111 held, rsp_ready=1, a_i=i+1 -> gnt sequence 0001,0010,0100,1000,0001 at 3-cycle spacing; rsp_z values 3,6,9,12.
REQ-034 Scenario: rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields unchanged, gnt=0 throughout; accept on the 6th cycle, next gnt 1 cycle later.
REQ-035 Scenario: reset pulsed in CALC with req=1000 pending -> rsp_valid stays 0; first post-reset grant goes to requester 3 (rr_ptr=0 scan).
REQ-036 Scenario: after requester 1 is served, req=0011 -> requester 0 wins only after the pointer wraps; requester 1 is not re-granted first.

Source files
------------

// File: rtl/engine_arb_if.sv
// engine_arb_if: request/response bundle between four requesters, one consumer and engine_arb.
// Latency: none; plain wires.
// Backpressure: req held until gnt; rsp_valid held until rsp_ready.
// Port summary: req/a_in/rsp_ready are driven by the requester side (master modport).
//               gnt/rsp_valid/rsp_id/rsp_z/busy[/ovf] are driven by the arbiter (slave modport).
// Optional: ovf exists only when ENGINE_ARB_OVF_EN is defined.
interface engine_arb_if #(parameter int WIDTH = 32);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] a_in;
  logic [3:0]         gnt;
  logic               rsp_valid;
  logic [1:0]         rsp_id;
  logic [WIDTH-1:0]   rsp_z;
  logic               rsp_ready;
  logic               busy;
`ifdef ENGINE_ARB_OVF_EN
  logic               ovf;

  modport master (output req, a_in, rsp_ready,
                  input  gnt, rsp_valid, rsp_id, rsp_z, busy, ovf);
  modport slave  (input  req, a_in, rsp_ready,
                  output gnt, rsp_valid, rsp_id, rsp_z, busy, ovf);
`else
  modport master (output req, a_in, rsp_ready,
                  input  gnt, rsp_valid, rsp_id, rsp_z, busy);
  modport slave  (input  req, a_in, rsp_ready,
                  output gnt, rsp_valid, rsp_id, rsp_z, busy);
`endif
endinterface

// File: rtl/engine_arb.sv
// engine_arb: round-robin arbiter feeding one shared times-3 engine, four requesters.
// Latency: gnt in cycle T -> rsp_valid in cycle T+2; at most one grant every 3 cycles.
// Backpressure: result held in HOLD until rsp_ready; requests wait (gnt=0) while busy.
// Ports: clk, reset (synchronous, active-high); bus (engine_arb_if.slave) carries
//        req/a_in/gnt, rsp_valid/rsp_id/rsp_z/rsp_ready, busy and optional ovf.
// Optional: define ENGINE_ARB_OVF_EN to add the registered carry-out flag ovf.
module engine_arb #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  engine_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t             state, state_nxt;
  logic [1:0]         rr_ptr;
  logic [1:0]         win;
  logic               any_req;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   a_lat;
  logic [1:0]         id_lat;
  logic [WIDTH+1:0]   prod;
  logic [3:0]         gnt_c;
  logic               accept;
  logic               rsp_valid_q;
  logic [1:0]         rsp_id_q;
  logic [WIDTH-1:0]   rsp_z_q;

  // Round-robin pick: scan offsets 3..0 so the smallest offset from rr_ptr wins last.
  always_comb begin
    logic [1:0] idx;
    win     = rr_ptr;
    idx     = rr_ptr;
    any_req = |bus.req;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (bus.req[idx]) win = idx;
    end
  end

  always_comb begin
    a_sel = '0;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) == win) a_sel = bus.a_in[k*WIDTH +: WIDTH];
    end
  end

  // The single engine: only the latched operand drives it; result is 3*a with carry bits on top.
  assign prod = {2'b00, a_lat} + {1'b0, a_lat, 1'b0};

  always_comb begin
    state_nxt = state;
    gnt_c     = 4'b0000;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_c[win] = 1'b1;
          state_nxt  = CALC;
        end
      end
      CALC: state_nxt = HOLD;
      HOLD: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The grant is combinational; mask it during reset since nothing is captured then.
  assign bus.gnt       = reset ? 4'b0000 : gnt_c;
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z     = rsp_z_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      a_lat       <= '0;
      id_lat      <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_z_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        a_lat  <= a_sel;
        id_lat <= win;
      end
      if (state == CALC) begin
        rsp_z_q     <= prod[WIDTH-1:0];
        rsp_id_q    <= id_lat;
        rsp_valid_q <= 1'b1;
      end
      if (accept) begin
        rsp_valid_q <= 1'b0;
        rr_ptr      <= rsp_id_q + 2'd1;
      end
    end
  end

`ifdef ENGINE_ARB_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;

  // 3*a can carry into either of the two bits above WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state == CALC) begin
      ovf_q <= |prod[WIDTH+1:WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_engine_arb.sv
// tb_engine_arb: directed checks of engine_arb grant order, latency, hold and reset behaviour.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns later.
// Backpressure: rsp_ready driven per scenario.
module tb_engine_arb;
  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  engine_arb_if #(.WIDTH(WIDTH)) bus();

  engine_arb #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_a(input int i, input logic [WIDTH-1:0] v);
    bus.a_in[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [WIDTH-1:0] z);
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, "_id"},    64'(bus.rsp_id),    64'(id));
    chk({tag, "_z"},     64'(bus.rsp_z),     64'(z));
  endtask

  logic [3:0]       exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [WIDTH-1:0] exp_z [5] = '{32'd3, 32'd6, 32'd9, 32'd12, 32'd3};

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.a_in = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    cyc(); cyc(); settle();
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_z", 64'(bus.rsp_z), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
`ifdef ENGINE_ARB_OVF_EN
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    reset = 1'b0;

    // Idle with no requests
    cyc(); settle();
    chk("idle_gnt", 64'(bus.gnt), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // Requester 0, a=5 -> 15 at T+2
    cyc();
    bus.req = 4'b0001; set_a(0, 32'd5); bus.rsp_ready = 1'b1;
    settle();
    chk("s1_gnt", 64'(bus.gnt), 64'b0001);
    cyc(); bus.req = 4'b0000; settle();
    chk("s1_calc_gnt", 64'(bus.gnt), 64'd0);
    chk("s1_calc_busy", 64'(bus.busy), 64'd1);
    chk("s1_calc_valid", 64'(bus.rsp_valid), 64'd0);
    cyc(); settle();
    chk_rsp("s1", 2'd0, 32'd15);
    cyc(); settle();
    chk("s1_cleared", 64'(bus.rsp_valid), 64'd0);
    chk("s1_idle_busy", 64'(bus.busy), 64'd0);

    // Requester 2 with overflowing operand, then a non-overflowing one
    bus.req = 4'b0100; set_a(2, 32'hFFFFFFFF); settle();
    chk("s2a_gnt", 64'(bus.gnt), 64'b0100);
    cyc(); bus.req = 4'b0000;
    cyc(); settle();
    chk_rsp("s2a", 2'd2, 32'hFFFFFFFD);
`ifdef ENGINE_ARB_OVF_EN
    chk("s2a_ovf", 64'(bus.ovf), 64'd1);
`endif
    cyc();
    bus.req = 4'b0100; set_a(2, 32'h55555555); settle();
    chk("s2b_gnt", 64'(bus.gnt), 64'b0100);
    cyc(); bus.req = 4'b0000;
    cyc(); settle();
    chk_rsp("s2b", 2'd2, 32'hFFFFFFFF);
`ifdef ENGINE_ARB_OVF_EN
    chk("s2b_ovf", 64'(bus.ovf), 64'd0);
`endif

    // Fairness from rr_ptr=0 with all requests held
    reset = 1'b1;
    cyc(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_a(i, 32'(i + 1));
    bus.req = 4'b1111; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("s3_gnt%0d", i), 64'(bus.gnt), 64'(exp_g[i]));
      cyc(); settle();
      chk($sformatf("s3_calc_gnt%0d", i), 64'(bus.gnt), 64'd0);
      cyc(); settle();
      chk($sformatf("s3_z%0d", i), 64'(bus.rsp_z), 64'(exp_z[i]));
      chk($sformatf("s3_hold_gnt%0d", i), 64'(bus.gnt), 64'd0);
      if (i == 4) bus.req = 4'b0000;
      cyc();
    end

    // Backpressure: rr_ptr=1, requester 1 a=7, hold ready low 5 cycles
    bus.req = 4'b0010; set_a(1, 32'd7); bus.rsp_ready = 1'b0; settle();
    chk("s4_gnt", 64'(bus.gnt), 64'b0010);
    cyc(); bus.req = 4'b0001; set_a(0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      chk_rsp($sformatf("s4_hold%0d", i), 2'd1, 32'd21);
      chk($sformatf("s4_hold_gnt%0d", i), 64'(bus.gnt), 64'd0);
    end
    cyc(); bus.rsp_ready = 1'b1; settle();
    chk_rsp("s4_acc", 2'd1, 32'd21);
    cyc(); settle();
    chk("s4_next_gnt", 64'(bus.gnt), 64'b0001);
    cyc(); bus.req = 4'b0000;
    cyc(); settle();
    chk_rsp("s4_r0", 2'd0, 32'd15);
    cyc();

    // Reset in CALC with requester 3 pending; rr_ptr=1 before reset
    bus.req = 4'b1000; set_a(3, 32'd9); settle();
    chk("s5_gnt", 64'(bus.gnt), 64'b1000);
    cyc(); settle();
    chk("s5_calc_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    cyc(); reset = 1'b0; settle();
    chk("s5_no_valid", 64'(bus.rsp_valid), 64'd0);
    chk("s5_busy", 64'(bus.busy), 64'd0);
    chk("s5_post_gnt", 64'(bus.gnt), 64'b1000);
    cyc(); bus.req = 4'b0000;
    cyc(); settle();
    chk_rsp("s5_r3", 2'd3, 32'd27);
    cyc();

    // Serve requester 1 (rr_ptr -> 2), then req=0011 must pick 0 first
    bus.req = 4'b0010; set_a(1, 32'd7); settle();
    chk("s6_g1", 64'(bus.gnt), 64'b0010);
    cyc(); bus.req = 4'b0000;
    cyc(); cyc();
    bus.req = 4'b0011; settle();
    chk("s6_wrap_gnt", 64'(bus.gnt), 64'b0001);
    cyc(); bus.req = 4'b0010;
    cyc(); settle();
    chk_rsp("s6_r0", 2'd0, 32'd15);
    cyc(); settle();
    chk("s6_then_gnt", 64'(bus.gnt), 64'b0010);
    cyc(); bus.req = 4'b0000;
    cyc(); settle();
    chk_rsp("s6_r1", 2'd1, 32'd21);

    // Reset wins over a same-cycle accept: rr_ptr must be 0, not 2
    reset = 1'b1;
    cyc(); reset = 1'b0;
    bus.req = 4'b0011; settle();
    chk("s7_rst_acc_gnt", 64'(bus.gnt), 64'b0001);
    chk("s7_valid", 64'(bus.rsp_valid), 64'd0);
    cyc(); bus.req = 4'b0000;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
